// File: rtl/spi_pkg.sv
// Shared definitions for the SPI write master and the downstream SPI receiver.
package spi_pkg;

  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned CMD_W      = 8;
  localparam int unsigned ADDR_W     = 24;
  localparam int unsigned DATA_W     = 32;

  localparam logic [CMD_W-1:0] CMD_WRITE = 8'hA4;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    TRAIL,
    GAP
  } spi_state_e;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } spi_frame_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick: a CLK_DIV down-counter that pulses tick_c once per CLK_DIV clk cycles.
module spi_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick_c
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  assign tick_c = (cnt == '0);

  // Restart aligns the first tick to exactly CLK_DIV cycles after frame acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick_c) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - ONE;
    end
  end

endmodule

// File: rtl/spi_write_master.sv
// SPI mode-0 write master: shifts a 64-bit {cmd, addr, data} frame out MSB first.
module spi_write_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_HALVES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              done,
  output logic              sck,
  output logic              cs,
  output logic              copi
);

  localparam int unsigned BIT_W    = $clog2(FRAME_BITS);
  localparam int unsigned GAP_W    = 12;
  localparam int unsigned GAP_CYC  = GAP_HALVES * CLK_DIV;
  // cs-high time includes the IDLE cycle in which ready is shown, so GAP is one cycle shorter.
  localparam int unsigned GAP_LAST = (GAP_CYC > 2) ? (GAP_CYC - 2) : 0;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_LAST);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  spi_state_e            state, state_d;
  logic [FRAME_BITS-1:0] shreg, shreg_d;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_d;
  logic [GAP_W-1:0]      gap_cnt, gap_cnt_d;
  logic                  sck_d, cs_d, copi_d, done_d, ready_d;
  logic                  tick_c;
  logic                  accept_c;
  spi_frame_t            frame_c;

  assign frame_c  = '{cmd: cmd, addr: addr, data: data};
  assign accept_c = (state == IDLE) && ready && start;

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (accept_c),
    .tick_c  (tick_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sck     <= 1'b0;
      cs      <= 1'b1;
      copi    <= 1'b0;
      done    <= 1'b0;
      ready   <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bit_cnt <= bit_cnt_d;
      gap_cnt <= gap_cnt_d;
      sck     <= sck_d;
      cs      <= cs_d;
      copi    <= copi_d;
      done    <= done_d;
      ready   <= ready_d;
    end
  end

  // Next-state and next-output logic; every pin is the flop of its *_d value.
  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
    gap_cnt_d = gap_cnt;
    sck_d     = sck;
    cs_d      = cs;
    copi_d    = copi;
    done_d    = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept_c) begin
          shreg_d   = frame_c;
          cs_d      = 1'b0;
          copi_d    = frame_c.cmd[CMD_W-1];
          bit_cnt_d = '0;
          state_d   = LEAD;
        end
      end
      LEAD, LOW: begin
        if (tick_c) begin
          sck_d   = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (tick_c) begin
          sck_d = 1'b0;
          if (bit_cnt == LAST_BIT) begin
            state_d = TRAIL;
          end else begin
            shreg_d   = shreg << 1;
            copi_d    = shreg[FRAME_BITS-2];
            bit_cnt_d = bit_cnt + BIT_ONE;
            state_d   = LOW;
          end
        end
      end
      TRAIL: begin
        if (tick_c) begin
          cs_d      = 1'b1;
          copi_d    = 1'b0;
          done_d    = 1'b1;
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_END) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt + GAP_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

endmodule
